// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller. It builds SRL, SLL, SRA and ROR out of one or two passes
// through an external combinational logical-right barrel shifter.
module shift_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    output logic [31:0]      sh_a,
    output logic [4:0]       sh_shamt,
    input  logic [31:0]      sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
    typedef enum logic [1:0] {OP_SRL, OP_SLL, OP_SRA, OP_ROR} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = out_result_q;
    assign op_count   = op_count_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        shamt_d      = shamt_q;
        acc_d        = acc_q;
        out_result_d = out_result_q;
        op_count_d   = op_count_q;
        sh_a         = 32'd0;
        sh_shamt     = 5'd0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_t'(in_op);
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                // SLL is a right shift of the bit-reversed operand, reversed back on the way out.
                sh_a     = (op_q == OP_SLL) ? bitrev(data_q) : data_q;
                sh_shamt = shamt_q;
                acc_d    = sh_result;
                if (op_q == OP_SRA || op_q == OP_ROR) begin
                    state_d = PASS2;
                end else begin
                    out_result_d = (op_q == OP_SLL) ? bitrev(sh_result) : sh_result;
                    state_d      = DONE;
                end
            end
            PASS2: begin
                if (op_q == OP_SRA) begin
                    sh_a     = 32'hFFFF_FFFF;
                    sh_shamt = shamt_q;
                    acc_d    = acc_q | (data_q[31] ? ~sh_result : 32'd0);
                end else begin
                    // Wrapped-around bits: data << (32 - shamt), done as a reversed right shift.
                    sh_a     = bitrev(data_q);
                    sh_shamt = ~shamt_q + 5'd1;
                    acc_d    = acc_q | bitrev(sh_result);
                end
                out_result_d = acc_d;
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_SRL;
            data_q       <= 32'd0;
            shamt_q      <= 5'd0;
            acc_q        <= 32'd0;
            out_result_q <= 32'd0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            shamt_q      <= shamt_d;
            acc_q        <= acc_d;
            out_result_q <= out_result_d;
            op_count_q   <= op_count_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed boundary cases plus randomized ops,
// compared against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_data;
    logic [4:0]       in_shamt;
    logic [31:0]      sh_a;
    logic [4:0]       sh_shamt;
    logic [31:0]      sh_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_count;

    always #5 clk = ~clk;

    // The shared barrel shifter: logical right shift, zero fill.
    assign sh_result = sh_a >> sh_shamt;

    shift_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .sh_a      (sh_a),
        .sh_shamt  (sh_shamt),
        .sh_result (sh_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] d, input int s);
        case (op)
            2'b00:   return d >> s;
            2'b01:   return d << s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_sh_a", sh_a, 32'd0);
        check("rst_sh_shamt", {27'd0, sh_shamt}, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_count = '0;
    endtask

    // Issues one op, checks shifter drive, latency, result, then holds out_ready low for
    // 'hold' DONE cycles (pulsing a rejected in_valid when hold >= 3) before the handshake.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s, input int hold);
        logic [31:0] expv;
        int          lat;
        int          exp_lat;
        expv    = ref_model(op, d, int'(s));
        exp_lat = op[1] ? 3 : 2;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        check("accept_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_shamt  = 5'($urandom);
        out_ready = 1'($urandom);
        lat = 1;
        check("pass1_sh_shamt", {27'd0, sh_shamt}, {27'd0, s});
        check("pass1_sh_a", sh_a, (op == 2'b01) ? rev32(d) : d);
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2 && op[1])
                check("pass2_sh_shamt", {27'd0, sh_shamt},
                      (op == 2'b11) ? 32'((32 - int'(s)) % 32) : {27'd0, s});
            if (!out_valid) out_ready = 1'($urandom);
        end
        if (!out_valid) begin
            check("timeout_out_valid", 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
        end
        // Counted from the accept cycle to the first cycle with out_valid high.
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", out_result, expv);
        check("done_sh_a", sh_a, 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = (hold >= 3 && i == 2);
            in_data  = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", out_result, expv);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_op_count", 32'(op_count), 32'(exp_count));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count = exp_count + 1'b1;
        check("op_count", 32'(op_count), 32'(exp_count));
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        in_op    = 2'b00;
        in_data  = 32'd0;
        in_shamt = 5'd0;
        do_reset();

        // Backpressure first so op_count visibly steps 0 -> 1 on release.
        run_op(2'b00, 32'h8000_0000, 5'd31, 5);

        run_op(2'b01, 32'h0000_0001, 5'd4, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 5'd31, 1);
        run_op(2'b10, 32'hF000_0000, 5'd4, 0);
        run_op(2'b10, 32'h7000_0000, 5'd4, 2);
        run_op(2'b10, 32'h8000_0000, 5'd31, 0);
        run_op(2'b11, 32'h1234_5678, 5'd8, 0);
        run_op(2'b11, 32'h1234_5678, 5'd0, 1);
        for (int op = 0; op < 4; op++) run_op(2'(op), 32'hDEAD_BEEF, 5'd0, 0);

        for (int n = 0; n < 40; n++)
            run_op(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 3)));

        // Abort an SRA in PASS2 with op_count at 3.
        do_reset();
        for (int n = 0; n < 3; n++) run_op(2'($urandom), $urandom, 5'($urandom), 0);
        check("pre_abort_op_count", 32'(op_count), 32'd3);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_data  = 32'h8000_0000;
        in_shamt = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_pass2", {31'd0, busy}, 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        check("abort_op_count_held", 32'(op_count), 32'd0);
        run_op(2'b00, 32'hA5A5_0F0F, 5'd7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
